// File: rtl/id_alu_decode.sv
// ID/EX issue stage: decodes one MIPS instruction into a one-hot ALU op and operands, and registers them behind a valid/ready handshake.
// Optional: define ID_DECODE_RI_EXC_EN to register a reserved-instruction flag on out_ri; otherwise out_ri is tied low.
module id_alu_decode (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_rs_value,
  input  logic [31:0] in_rt_value,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_aluop,
  output logic [31:0] out_src1,
  output logic [31:0] out_src2,
  output logic [4:0]  out_dest,
  output logic        out_reg_we,
  output logic        out_mem_re,
  output logic        out_mem_we,
  output logic [31:0] out_store_data,
  output logic        out_ri
);
  localparam logic [11:0] OP_ADD  = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                          OP_OR   = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                          OP_SRL  = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

  typedef struct packed {
    logic [11:0] aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] store_data;
  } idex_t;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, sa;
  logic [31:0] sext, zext;
  logic        unused_rs_field;
  idex_t       dec, q;
  logic        vld_q, accept;

  assign op    = in_inst[31:26];
  assign rt    = in_inst[20:16];
  assign rd    = in_inst[15:11];
  assign sa    = in_inst[10:6];
  assign funct = in_inst[5:0];
  assign sext  = {{16{in_inst[15]}}, in_inst[15:0]};
  assign zext  = {16'b0, in_inst[15:0]};
  // Register operands arrive already forwarded, so the rs field itself is not needed.
  assign unused_rs_field = ^in_inst[25:21];

  always_comb begin
    dec      = '0;
    dec.src1 = in_rs_value;
    dec.src2 = in_rt_value;
    case (op)
      6'h00: begin
        dec.dest   = rd;
        dec.reg_we = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.aluop = OP_ADD;
          6'h22, 6'h23: dec.aluop = OP_SUB;
          6'h2a: dec.aluop = OP_SLT;
          6'h2b: dec.aluop = OP_SLTU;
          6'h24: dec.aluop = OP_AND;
          6'h25: dec.aluop = OP_OR;
          6'h26: dec.aluop = OP_XOR;
          6'h27: dec.aluop = OP_NOR;
          6'h00: begin dec.aluop = OP_SLL; dec.src1 = {27'b0, sa}; end
          6'h02: begin dec.aluop = OP_SRL; dec.src1 = {27'b0, sa}; end
          6'h03: begin dec.aluop = OP_SRA; dec.src1 = {27'b0, sa}; end
          6'h04: dec.aluop = OP_SLL;
          6'h06: dec.aluop = OP_SRL;
          6'h07: dec.aluop = OP_SRA;
          default: dec.reg_we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.aluop = OP_ADD;  dec.src2 = sext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0a:        begin dec.aluop = OP_SLT;  dec.src2 = sext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0b:        begin dec.aluop = OP_SLTU; dec.src2 = sext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0c:        begin dec.aluop = OP_AND;  dec.src2 = zext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0d:        begin dec.aluop = OP_OR;   dec.src2 = zext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0e:        begin dec.aluop = OP_XOR;  dec.src2 = zext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h0f:        begin dec.aluop = OP_LUI;  dec.src2 = zext; dec.dest = rt; dec.reg_we = 1'b1; end
      6'h23: begin
        dec.aluop = OP_ADD; dec.src2 = sext; dec.dest = rt; dec.reg_we = 1'b1; dec.mem_re = 1'b1;
      end
      6'h2b: begin
        dec.aluop = OP_ADD; dec.src2 = sext; dec.mem_we = 1'b1; dec.store_data = in_rt_value;
      end
      default: ;
    endcase
    if (!dec.reg_we) dec.dest = '0;
  end

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      q     <= dec;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

`ifdef ID_DECODE_RI_EXC_EN
  logic ri_q;
  // Every legal encoding sets exactly one aluop bit, so an empty aluop marks a reserved one.
  always_ff @(posedge clk) begin
    if (!resetn)     ri_q <= 1'b0;
    else if (accept) ri_q <= ~|dec.aluop;
  end
  assign out_ri = ri_q;
`else
  assign out_ri = 1'b0;
`endif

  assign out_valid      = vld_q;
  assign out_aluop      = q.aluop;
  assign out_src1       = q.src1;
  assign out_src2       = q.src2;
  assign out_dest       = q.dest;
  assign out_reg_we     = q.reg_we;
  assign out_mem_re     = q.mem_re;
  assign out_mem_we     = q.mem_we;
  assign out_store_data = q.store_data;
endmodule

// File: tb/tb_id_alu_decode.sv
// Directed bench for id_alu_decode: decode vectors, backpressure, flush and mid-stream reset.
module tb_id_alu_decode;
  logic        clk = 1'b0;
  logic        resetn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_rs_value, in_rt_value;
  logic [11:0] out_aluop;
  logic [31:0] out_src1, out_src2, out_store_data;
  logic [4:0]  out_dest;
  logic        out_reg_we, out_mem_re, out_mem_we, out_ri;
  int          n_chk = 0, n_fail = 0;
`ifdef ID_DECODE_RI_EXC_EN
  localparam logic EXP_RI = 1'b1;
`else
  localparam logic EXP_RI = 1'b0;
`endif

  id_alu_decode dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rs_value(in_rs_value), .in_rt_value(in_rt_value),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_aluop(out_aluop), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest(out_dest), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
    .out_mem_we(out_mem_we), .out_store_data(out_store_data), .out_ri(out_ri)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1; in_inst = inst; in_rs_value = rs; in_rt_value = rt;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_rs_value = '0; in_rt_value = '0;
    step(); step();
    chk("rst_valid", out_valid, 0);  chk("rst_aluop", out_aluop, 0);
    chk("rst_src1", out_src1, 0);    chk("rst_src2", out_src2, 0);
    chk("rst_dest", out_dest, 0);    chk("rst_we", out_reg_we, 0);
    chk("rst_ri", out_ri, 0);        chk("rst_in_ready", in_ready, 1);
    resetn = 1'b1;

    offer(32'h00221821, 32'd5, 32'd7); step();            // addu $3,$1,$2
    chk("addu_valid", out_valid, 1); chk("addu_aluop", out_aluop, 12'h800);
    chk("addu_src1", out_src1, 5);   chk("addu_src2", out_src2, 7);
    chk("addu_dest", out_dest, 3);   chk("addu_we", out_reg_we, 1);
    chk("addu_mre", out_mem_re, 0);

    offer(32'h00021903, 32'h1234, 32'h80000000); step();   // sra $3,$2,4
    chk("sra_valid", out_valid, 1);  chk("sra_aluop", out_aluop, 12'h002);
    chk("sra_src1", out_src1, 4);    chk("sra_src2", out_src2, 32'h80000000);
    chk("sra_dest", out_dest, 3);

    offer(32'h3C051234, 32'h0, 32'h0); step();             // lui $5,0x1234
    chk("lui_aluop", out_aluop, 12'h001); chk("lui_src2", out_src2, 32'h00001234);
    chk("lui_dest", out_dest, 5);         chk("lui_we", out_reg_we, 1);

    offer(32'h2422FFFF, 32'd10, 32'h0); step();            // addiu $2,$1,-1
    chk("addiu_aluop", out_aluop, 12'h800); chk("addiu_src1", out_src1, 10);
    chk("addiu_src2", out_src2, 32'hFFFFFFFF); chk("addiu_dest", out_dest, 2);

    offer(32'h3422FFFF, 32'd10, 32'h0); step();            // ori $2,$1,0xffff
    chk("ori_aluop", out_aluop, 12'h020); chk("ori_src2", out_src2, 32'h0000FFFF);

    offer(32'h2C22FFFF, 32'd10, 32'h0); step();            // sltiu: sign-extended
    chk("sltiu_aluop", out_aluop, 12'h100); chk("sltiu_src2", out_src2, 32'hFFFFFFFF);

    offer(32'h8C43FFFC, 32'h100, 32'h55); step();          // lw $3,-4($2)
    chk("lw_aluop", out_aluop, 12'h800); chk("lw_src2", out_src2, 32'hFFFFFFFC);
    chk("lw_mre", out_mem_re, 1);        chk("lw_dest", out_dest, 3);
    chk("lw_we", out_reg_we, 1);

    offer(32'hAC430008, 32'h100, 32'hCAFEBABE); step();    // sw $3,8($2)
    chk("sw_aluop", out_aluop, 12'h800); chk("sw_mwe", out_mem_we, 1);
    chk("sw_data", out_store_data, 32'hCAFEBABE);
    chk("sw_we", out_reg_we, 0);         chk("sw_dest", out_dest, 0);

    offer(32'h00431022, 32'd9, 32'd4); step();             // sub $2,$2,$3
    chk("sub_aluop", out_aluop, 12'h400); chk("sub_dest", out_dest, 2);

    offer(32'h00431027, 32'd9, 32'd4); step();             // nor
    chk("nor_aluop", out_aluop, 12'h040);

    offer(32'hFC000000, 32'd9, 32'd4); step();             // reserved
    chk("ri_valid", out_valid, 1); chk("ri_aluop", out_aluop, 0);
    chk("ri_we", out_reg_we, 0);   chk("ri_flag", out_ri, EXP_RI);
    chk("ri_dest", out_dest, 0);   chk("ri_mwe", out_mem_we, 0);

    offer(32'h00431004, 32'd3, 32'd1); step();             // sllv
    chk("sllv_aluop", out_aluop, 12'h008); chk("sllv_src1", out_src1, 3);
    chk("sllv_ri", out_ri, 0);

    in_valid = 1'b0; step();
    chk("drain_valid", out_valid, 0); chk("drain_hold", out_aluop, 12'h008);

    // Backpressure: A held two cycles while B waits, then B and C follow in order.
    offer(32'h00221821, 32'hA, 32'h1); step();
    out_ready = 1'b0; offer(32'h00431022, 32'hB, 32'h2); #1;
    chk("bp_in_ready", in_ready, 0);
    step(); chk("bp_hold1_src1", out_src1, 32'hA); chk("bp_hold1_valid", out_valid, 1);
    step(); chk("bp_hold2_src1", out_src1, 32'hA); chk("bp_hold2_aluop", out_aluop, 12'h800);
    out_ready = 1'b1; #1; chk("bp_release_ready", in_ready, 1);
    step(); chk("bp_b_src1", out_src1, 32'hB); chk("bp_b_aluop", out_aluop, 12'h400);
    offer(32'h00431027, 32'hC, 32'h3); step();
    chk("bp_c_src1", out_src1, 32'hC); chk("bp_c_valid", out_valid, 1);
    in_valid = 1'b0; step(); chk("bp_empty", out_valid, 0);

    // Flush squashes the held instruction and the one offered alongside it.
    offer(32'h00221821, 32'h11, 32'h1); step();
    flush = 1'b1; offer(32'h3C051234, 32'h0, 32'h0); #1;
    chk("fl_in_ready", in_ready, 1);
    step(); chk("fl_valid", out_valid, 0); chk("fl_no_lui", out_aluop, 12'h800);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("fl_still_empty", out_valid, 0); chk("fl_src1_hold", out_src1, 32'h11);

    // Reset mid-stream with an instruction offered.
    offer(32'hAC430008, 32'h100, 32'hDEADBEEF); step();
    chk("mr_pre_valid", out_valid, 1); chk("mr_pre_data", out_store_data, 32'hDEADBEEF);
    resetn = 1'b0; offer(32'h00221821, 32'd5, 32'd7); step();
    chk("mr_valid", out_valid, 0); chk("mr_aluop", out_aluop, 0);
    chk("mr_src1", out_src1, 0);   chk("mr_src2", out_src2, 0);
    chk("mr_dest", out_dest, 0);   chk("mr_we", out_reg_we, 0);
    chk("mr_mre", out_mem_re, 0);  chk("mr_mwe", out_mem_we, 0);
    chk("mr_data", out_store_data, 0); chk("mr_ri", out_ri, 0);
    resetn = 1'b1; step();
    chk("post_rst_addu", out_aluop, 12'h800); chk("post_rst_valid", out_valid, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/id_alu_decode.md
# id_alu_decode

Decode-to-execute issue stage for the five-stage MIPS core. Decodes one 32-bit instruction per cycle into the 12-bit one-hot ALU operation vector and the two selected ALU operands. It registers these fields into the ID/EX pipeline register, which uses a valid/ready handshake on both sides. This block is the producer side of the ALU's `aluop`/`alu_in_1`/`alu_in_2` interface: EX feeds its outputs straight into the ALU.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `in_valid`  in  1  — ID holds a valid instruction.
- `in_ready`  out  1  — stage can accept; `in_ready = !out_valid || out_ready`.
- `in_inst`  in  32  — instruction word.
- `in_rs_value`  in  32  — forwarded rs register value.
- `in_rt_value`  in  32  — forwarded rt register value.
- `flush`  in  1  — squash the held instruction (branch/exception redirect).
- `out_valid`  out  1  — ID/EX register holds a valid instruction.
- `out_ready`  in  1  — EX accepts this cycle.
- `out_aluop`  out  12  — one-hot: [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
- `out_src1`  out  32  — ALU operand 1; shift amount in bits [4:0] for shifts.
- `out_src2`  out  32  — ALU operand 2; shifted value for shifts.
- `out_dest`  out  5  — write-back register number.
- `out_reg_we`  out  1  — write-back enable.
- `out_mem_re`, `out_mem_we`  out  1 each  — LW / SW markers.
- `out_store_data`  out  32  — rt value for SW.
- `out_ri`  out  1  — reserved-instruction flag (see Configuration).

## Operation
- R-type (op=0, by funct):
  - 0x20/0x21 → add; 0x22/0x23 → sub; 0x2a slt; 0x2b sltu; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor.
  - Operands: src1=rs, src2=rt; dest=rd; reg_we=1.
- Shifts by immediate: funct 0x00 sll, 0x02 srl, 0x03 sra; src1={27'b0,sa}, src2=rt.
- Shifts by register: funct 0x04 sllv, 0x06 srlv, 0x07 srav; src1=rs, src2=rt.
- I-type, add class: 0x08/0x09 → add; src2 = sign-extended imm16.
- I-type, compare class: 0x0a → slt, 0x0b → sltu; src2 = sign-extended imm16, including sltu.
- I-type, logical class: 0x0c and, 0x0d or, 0x0e xor; src2 = zero-extended imm16.
- I-type common rules: src1=rs, dest=rt, reg_we=1.
- LUI (0x0f): lui; src2={16'b0,imm16}; dest=rt; reg_we=1.
- LW (0x23): add, src1=rs, src2=sext(imm); mem_re=1; dest=rt; reg_we=1.
- SW (0x2b): add, src1=rs, src2=sext(imm); mem_we=1; store_data=rt; reg_we=0.
- Any other encoding: aluop=0, reg_we=0, mem_re=0, mem_we=0, ri=1 (macro enabled).
- `out_dest` is always 0 when reg_we=0. A write to $0 keeps reg_we=1; the register file ignores it.
- Exactly one aluop bit is set for every legal instruction.

## Timing
- Reset (resetn=0 at an edge): out_valid=0, and every payload output is 0 (aluop, src1, src2, dest, reg_we, mem_re, mem_we, store_data, ri).
- Latency: one cycle. An instruction accepted at edge N appears on outputs after edge N.
- Accept: register loads when `in_valid && in_ready && !flush`; out_valid←1.
- Drain: when `out_valid && out_ready` and no new accept, out_valid←0; payload holds its last value.
- Backpressure: while `out_valid && !out_ready`, all outputs are stable and in_ready=0.
- Full throughput: with out_ready=1 continuously, one instruction per cycle and no bubbles.
- Flush: out_valid←0 at the next edge. It overrides both accept and hold, and an instruction offered in the same cycle is discarded. in_ready is not gated by flush.
- Reset overrides flush and accept.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_inst.

## Configuration
- Macro: `ID_DECODE_RI_EXC_EN`.
- Defined:
  - Unknown encodings pass through with ri=1, aluop=0 and no write or memory side effects.
  - `out_ri` is registered like the other payload fields.
- Undefined:
  - `out_ri` is tied to 0.
  - Unknown encodings still issue as aluop=0, reg_we=0, mem_re=0 and mem_we=0, acting as a NOP.

## Test plan
- **ADDU:** inst 0x00221821, rs=5, rt=7, out_ready=1 → next cycle out_valid=1, aluop=0x800, src1=5, src2=7, dest=3, reg_we=1.
- **SRA:** inst 0x00021903, rt=0x80000000 → aluop=0x002, src1=4, src2=0x80000000, dest=3.
- **Immediate extension:**
  - LUI 0x3C051234 → aluop=0x001, src2=0x00001234, dest=5.
  - ADDIU 0x2422FFFF → aluop=0x800, src2=0xFFFFFFFF, dest=2.
  - ORI 0x3422FFFF → aluop=0x020, src2=0x0000FFFF.
- **Backpressure:** issue 3 back-to-back instructions with out_ready=0 for 2 cycles after the first → first held stable, in_ready=0, and no instruction lost or duplicated once out_ready=1.
- **Flush:** flush=1 with out_valid=1 and in_valid=1 → next cycle out_valid=0 and the offered instruction never appears. Also assert resetn=0 mid-stream → out_valid=0 and all outputs 0 after one edge.
- **Reserved instruction:** inst 0xFC000000 → with macro: out_valid=1, aluop=0, ri=1, reg_we=0. Without macro: same but ri=0.
